// File: rtl/bsg_manycore_ruche_x_link_pipe_if.sv
// Ruche-X link bundle: per-lane valid/ready handshake plus flat payload.
// Ports: v (lanes_p), data (lanes_p*width_p), ready (lanes_p); master drives v/data.
interface bsg_manycore_ruche_x_link_pipe_if #(
  parameter int width_p = 8,
  parameter int lanes_p = 3
);
  logic [lanes_p-1:0]         v;
  logic [lanes_p*width_p-1:0] data;
  logic [lanes_p-1:0]         ready;

  modport master (output v, output data, input ready);
  modport slave  (input v, input data, output ready);
endinterface

// File: rtl/bsg_manycore_ruche_x_link_pipe.sv
// Elastic ruche-X link pipe: per-lane skid-buffer chain, output rotation/inversion.
// Ports: clk_i, reset_ni, link_i (slave: v_i/data_i/ready_o), link_o (master:
// v_o/data_o/ready_i), stat_clear_i, stall_cnt_o. Stall counters built only
// when BSG_MANYCORE_RUCHE_PIPE_STATS_EN is defined.
module bsg_manycore_ruche_x_link_pipe #(
  parameter int width_p        = 8,
  parameter int ruche_factor_p = 3,
  parameter int num_stages_p   = 2,
  parameter int rotate_p       = 1,
  parameter logic [ruche_factor_p-1:0] invert_mask_p = '0,
  parameter int stat_width_p   = 32
) (
  input  logic clk_i,
  input  logic reset_ni,
  bsg_manycore_ruche_x_link_pipe_if.slave  link_i,
  bsg_manycore_ruche_x_link_pipe_if.master link_o,
  input  logic stat_clear_i,
  output logic [ruche_factor_p*stat_width_p-1:0] stall_cnt_o
);
  localparam int R = ruche_factor_p;
  localparam int N = num_stages_p;
  localparam int W = width_p;

  logic [R-1:0] w_lv;
  logic [R-1:0] w_dn_rdy;
  logic [W-1:0] w_ld [R];
  logic [R-1:0] w_vo;

  for (genvar l = 0; l < R; l++) begin : g_lane
    localparam int DST = (rotate_p != 0) ? (l + 1) % R : l;

    logic [N:0]   w_v;
    logic [N:0]   w_rdy;
    logic [W-1:0] w_d [N+1];

    assign w_v[0]   = link_i.v[l];
    assign w_d[0]   = link_i.data[l*W +: W];
    assign w_rdy[N] = w_dn_rdy[l];
    assign w_dn_rdy[l] = link_o.ready[DST];

    for (genvar s = 0; s < N; s++) begin : g_stg
      logic [1:0]   r_cnt;
      logic         r_rdy;
      logic [W-1:0] r_head;
      logic [W-1:0] r_skid;
      logic         w_enq;
      logic         w_deq;
      logic [1:0]   w_cnt_n;

      assign w_enq = w_v[s] & r_rdy;
      assign w_deq = (r_cnt != 2'd0) & w_rdy[s+1];

      always_comb begin
        w_cnt_n = r_cnt;
        if (w_enq && !w_deq)
          w_cnt_n = r_cnt + 2'd1;
        else if (!w_enq && w_deq)
          w_cnt_n = r_cnt - 2'd1;
      end

      // r_head is the visible entry; r_skid catches the beat that
      // arrives while the head is stalled.
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          r_cnt  <= '0;
          r_rdy  <= 1'b0;
          r_head <= '0;
          r_skid <= '0;
        end else begin
          r_cnt <= w_cnt_n;
          r_rdy <= (w_cnt_n != 2'd2);
          if (w_enq && (r_cnt == 2'd0 || w_deq))
            r_head <= w_d[s];
          else if (w_deq && r_cnt == 2'd2)
            r_head <= r_skid;
          if (w_enq && !w_deq && r_cnt == 2'd1)
            r_skid <= w_d[s];
        end
      end

      assign w_v[s+1]  = (r_cnt != 2'd0);
      assign w_d[s+1]  = r_head;
      assign w_rdy[s]  = r_rdy;
    end

    // Gating by reset matters only for the stateless pass-through build.
    assign link_i.ready[l] = w_rdy[0] & reset_ni;
    assign w_lv[l] = w_v[N];
    assign w_ld[l] = w_d[N];
  end

  for (genvar k = 0; k < R; k++) begin : g_out
    localparam int SRC = (rotate_p != 0) ? (k + R - 1) % R : k;
    logic w_inv;

    assign w_vo[k] = w_lv[SRC] & reset_ni;
    assign w_inv   = invert_mask_p[k] & w_vo[k];
    assign link_o.v[k] = w_vo[k];
    assign link_o.data[k*W +: W] =
      {W{reset_ni}} & (w_ld[SRC] ^ {W{w_inv}});
  end

`ifdef BSG_MANYCORE_RUCHE_PIPE_STATS_EN
  for (genvar k = 0; k < R; k++) begin : g_st
    logic [stat_width_p-1:0] r_st;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)
        r_st <= '0;
      else if (stat_clear_i)
        r_st <= '0;
      else if (w_vo[k] && !link_o.ready[k] && !(&r_st))
        r_st <= r_st + stat_width_p'(1);
    end

    assign stall_cnt_o[k*stat_width_p +: stat_width_p] = r_st;
  end
`else
  logic w_unused;
  assign w_unused    = stat_clear_i;
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_pipe.sv
// Bench for the ruche-X link pipe: a 2-stage rotated/inverted instance and a
// 0-stage pass-through instance, checked against queue-based lane models.
module tb_bsg_manycore_ruche_x_link_pipe;
  localparam int W = 8;
  localparam int R = 3;
  localparam logic [2:0] MA = 3'b010;
  localparam logic [2:0] MB = 3'b100;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [R*4-1:0] sa;
  logic [R*4-1:0] sb;
  int n_cmp = 0;
  int n_bad = 0;
  byte_t mq [3][$];

  bsg_manycore_ruche_x_link_pipe_if #(.width_p(W), .lanes_p(R)) ai ();
  bsg_manycore_ruche_x_link_pipe_if #(.width_p(W), .lanes_p(R)) ao ();
  bsg_manycore_ruche_x_link_pipe_if #(.width_p(W), .lanes_p(R)) bi ();
  bsg_manycore_ruche_x_link_pipe_if #(.width_p(W), .lanes_p(R)) bo ();

  bsg_manycore_ruche_x_link_pipe #(
    .width_p(W), .ruche_factor_p(R), .num_stages_p(2),
    .rotate_p(1), .invert_mask_p(MA), .stat_width_p(4)
  ) u_a (
    .clk_i(clk), .reset_ni(rst_n), .link_i(ai), .link_o(ao),
    .stat_clear_i(clr), .stall_cnt_o(sa)
  );

  bsg_manycore_ruche_x_link_pipe #(
    .width_p(W), .ruche_factor_p(R), .num_stages_p(0),
    .rotate_p(1), .invert_mask_p(MB), .stat_width_p(4)
  ) u_b (
    .clk_i(clk), .reset_ni(rst_n), .link_i(bi), .link_o(bo),
    .stat_clear_i(clr), .stall_cnt_o(sb)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    ai.v = '0; ai.data = '0; ao.ready = '1;
    bi.v = 3'b111; bi.data = 24'hFFFFFF; bo.ready = 3'b111;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ao.v !== 3'b000) begin
      n_bad++; $display("FAIL reset_v got %b want 000", ao.v);
    end
    n_cmp++;
    if (ai.ready !== 3'b000) begin
      n_bad++; $display("FAIL reset_rdy got %b want 000", ai.ready);
    end
    n_cmp++;
    if (ao.data !== 24'h0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", ao.data);
    end
    n_cmp++;
    if (sa !== 12'h0 || sb !== 12'h0) begin
      n_bad++; $display("FAIL reset_stall got %h/%h want 0", sa, sb);
    end
    n_cmp++;
    if (bo.v !== 3'b000 || bi.ready !== 3'b000 || bo.data !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_pass got v=%b r=%b d=%h want 0",
               bo.v, bi.ready, bo.data);
    end
    bi.v = '0; bi.data = '0; bo.ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ai.ready !== 3'b000) begin
      n_bad++; $display("FAIL rdy_before_edge got %b want 000", ai.ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ai.ready !== 3'b111) begin
      n_bad++; $display("FAIL rdy_after_edge got %b want 111", ai.ready);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    ai.v = 3'b001; ai.data = 24'h0000A5; ao.ready = 3'b111;
    #1;
    n_cmp++;
    if (ai.ready[0] !== 1'b1 || ao.v !== 3'b000) begin
      n_bad++;
      $display("FAIL lat_c0 got r=%b v=%b want r=1 v=000", ai.ready[0], ao.v);
    end
    @(negedge clk);
    ai.v = '0; ai.data = '0;
    #1;
    n_cmp++;
    if (ao.v !== 3'b000) begin
      n_bad++; $display("FAIL lat_c1 got v=%b want 000", ao.v);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ao.v !== 3'b010) begin
      n_bad++; $display("FAIL lat_c2 got v=%b want 010", ao.v);
    end
    n_cmp++;
    if (ao.data[15:8] !== 8'h5A) begin
      n_bad++; $display("FAIL lat_inv got %h want 5a", ao.data[15:8]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ao.v !== 3'b000) begin
      n_bad++; $display("FAIL lat_c3 got v=%b want 000", ao.v);
    end
    ai.v = 3'b111; ai.data = 24'h0F3CA5;
    @(negedge clk);
    ai.v = '0; ai.data = '0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ao.v !== 3'b111) begin
      n_bad++; $display("FAIL lat_all_v got %b want 111", ao.v);
    end
    n_cmp++;
    if (ao.data !== 24'h3C5A0F) begin
      n_bad++; $display("FAIL lat_all_d got %h want 3c5a0f", ao.data);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int nxt = 0;
    int n1 = 0;
    int n2 = 0;
    bit saw_low = 0;
    bit saw_rise = 0;
    byte_t got [$];
    int gcyc [$];
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      ai.v = {nxt < 10, 1'b1, 1'b1};
      ai.data = {byte_t'(nxt), byte_t'(c), byte_t'(c)};
      ao.ready = {2'b11, !(c >= 3 && c <= 7)};
      #1;
      if (ao.v[0] && ao.ready[0]) begin
        got.push_back(ao.data[7:0]);
        gcyc.push_back(c);
      end
      if (ao.v[1]) begin
        n1++;
        n_cmp++;
        if ((ao.data[15:8] ^ 8'hFF) !== byte_t'(c - 2)) begin
          n_bad++;
          $display("FAIL strm_l1 c=%0d got %h want %h",
                   c, ao.data[15:8] ^ 8'hFF, byte_t'(c - 2));
        end
      end
      if (ao.v[2]) begin
        n2++;
        n_cmp++;
        if (ao.data[23:16] !== byte_t'(c - 2)) begin
          n_bad++;
          $display("FAIL strm_l2 c=%0d got %h want %h",
                   c, ao.data[23:16], byte_t'(c - 2));
        end
      end
      n_cmp++;
      if (ai.ready[1:0] !== 2'b11) begin
        n_bad++;
        $display("FAIL strm_indep c=%0d got %b want 11", c, ai.ready[1:0]);
      end
      if (!ai.ready[2]) saw_low = 1;
      else if (saw_low) saw_rise = 1;
      if (ai.v[2] && ai.ready[2]) nxt++;
    end
    n_cmp++;
    if (n1 != 22 || n2 != 22) begin
      n_bad++; $display("FAIL strm_rate got %0d/%0d want 22/22", n1, n2);
    end
    n_cmp++;
    if (!saw_low || !saw_rise) begin
      n_bad++;
      $display("FAIL strm_bp_rdy got low=%0d rise=%0d want 1/1",
               saw_low, saw_rise);
    end
    n_cmp++;
    if (got.size() != 10) begin
      n_bad++; $display("FAIL strm_cnt got %0d want 10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (got[i] !== byte_t'(i) ||
            gcyc[i] != ((i == 0) ? 2 : 7 + i)) begin
          n_bad++;
          $display("FAIL strm_seq i=%0d got %h@%0d want %h@%0d",
                   i, got[i], gcyc[i], byte_t'(i), (i == 0) ? 2 : 7 + i);
        end
      end
    end
    @(negedge clk);
    ai.v = '0; ao.ready = '1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] hv = '0;
    logic [2:0] ma = MA;
    byte_t exp_d;
    int s;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if (!hv[l]) begin
          ai.v[l] = (c < 400) && ($urandom_range(0, 3) != 0);
          ai.data[l*8 +: 8] = 8'($urandom);
        end
      end
      ao.ready = (c < 400) ? 3'($urandom) : 3'b111;
      #1;
      for (int l = 0; l < 3; l++) begin
        n_cmp++;
        if (mq[l].size() > 4) begin
          n_bad++;
          $display("FAIL rnd_occ lane=%0d got %0d want <=4", l, mq[l].size());
        end
      end
      for (int k = 0; k < 3; k++) begin
        s = (k + 2) % 3;
        if (ao.v[k]) begin
          n_cmp++;
          if (mq[s].size() == 0) begin
            n_bad++;
            $display("FAIL rnd_spurious out=%0d got v=1 want v=0", k);
          end else begin
            exp_d = mq[s][0] ^ {8{ma[k]}};
            if (ao.data[k*8 +: 8] !== exp_d) begin
              n_bad++;
              $display("FAIL rnd_data out=%0d got %h want %h",
                       k, ao.data[k*8 +: 8], exp_d);
            end
            if (ao.ready[k]) void'(mq[s].pop_front());
          end
        end
      end
      for (int l = 0; l < 3; l++) begin
        if (ai.v[l] && ai.ready[l]) mq[l].push_back(ai.data[l*8 +: 8]);
        hv[l] = ai.v[l] && !ai.ready[l];
      end
    end
    n_cmp++;
    if (mq[0].size() + mq[1].size() + mq[2].size() != 0 || hv != 0) begin
      n_bad++;
      $display("FAIL rnd_drain got %0d/%0d/%0d held=%b want empty",
               mq[0].size(), mq[1].size(), mq[2].size(), hv);
    end
    @(negedge clk);
    ai.v = '0;
  endtask

  task automatic test_passthrough();
    logic [2:0] mb = MB;
    int s;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bi.v = 3'($urandom);
      bi.data = 24'($urandom);
      bo.ready = 3'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        s = (k + 2) % 3;
        n_cmp++;
        if (bo.v[k] !== bi.v[s]) begin
          n_bad++;
          $display("FAIL pass_v out=%0d got %b want %b", k, bo.v[k], bi.v[s]);
        end
        if (bi.v[s]) begin
          n_cmp++;
          if (bo.data[k*8 +: 8] !== (bi.data[s*8 +: 8] ^ {8{mb[k]}})) begin
            n_bad++;
            $display("FAIL pass_d out=%0d got %h want %h", k,
                     bo.data[k*8 +: 8], bi.data[s*8 +: 8] ^ {8{mb[k]}});
          end
        end
        n_cmp++;
        if (bi.ready[k] !== bo.ready[(k + 1) % 3]) begin
          n_bad++;
          $display("FAIL pass_rdy lane=%0d got %b want %b",
                   k, bi.ready[k], bo.ready[(k + 1) % 3]);
        end
      end
    end
    bi.v = '0; bi.data = '0; bo.ready = '0;
  endtask

  task automatic test_stats();
    @(negedge clk);
    ai.v = '0; ao.ready = 3'b110; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if (sa !== 12'h0) begin
      n_bad++; $display("FAIL st_clr0 got %h want 0", sa);
    end
    ai.v = 3'b100; ai.data = 24'h770000;
    @(negedge clk);
    ai.v = '0; ai.data = '0;
    repeat (22) @(negedge clk);
    #1;
    n_cmp++;
    if (ao.v[0] !== 1'b1 || ao.data[7:0] !== 8'h77) begin
      n_bad++;
      $display("FAIL st_hold got v=%b d=%h want 1/77", ao.v[0], ao.data[7:0]);
    end
`ifdef BSG_MANYCORE_RUCHE_PIPE_STATS_EN
    n_cmp++;
    if (sa !== 12'h00F) begin
      n_bad++; $display("FAIL st_sat got %h want 00f", sa);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if (sa[3:0] !== 4'd0) begin
      n_bad++; $display("FAIL st_clr got %h want 0", sa[3:0]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sa[3:0] !== 4'd1) begin
      n_bad++; $display("FAIL st_resume got %h want 1", sa[3:0]);
    end
`else
    n_cmp++;
    if (sa !== 12'h0) begin
      n_bad++; $display("FAIL st_off got %h want 0", sa);
    end
`endif
    ao.ready = 3'b111;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit stale = 0;
    @(negedge clk);
    ao.ready = 3'b101;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      ai.v = 3'b001; ai.data = {16'h0, byte_t'(8'h10 + i)};
      #1;
      n_cmp++;
      if (ai.ready[0] !== 1'b1) begin
        n_bad++; $display("FAIL mid_fill i=%0d got 0 want 1", i);
      end
    end
    @(negedge clk);
    ai.v = '0; ai.data = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ao.v !== 3'b000 || ai.ready !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_async got v=%b r=%b want 000/000", ao.v, ai.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ao.ready = 3'b111;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ai.ready !== 3'b111) begin
      n_bad++; $display("FAIL mid_rdy got %b want 111", ai.ready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (ao.v !== 3'b000) stale = 1;
    end
    n_cmp++;
    if (stale) begin
      n_bad++; $display("FAIL mid_stale got v=1 want none");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_random();
    test_passthrough();
    test_stats();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
